// File: rtl/pc_jump_unit.sv
// pc_jump_unit: fetch-stage PC register and next-PC generator.
// Covers sequential, branch, J, JAL, JR and return flow. JAL pushes its link
// address onto a small circular return-address stack, and RET pops it.
module pc_jump_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                IDX_W     = 26,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        mode,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [IDX_W-1:0]  instr_idx,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf
);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [2:0] M_BR  = 3'd1;
    localparam logic [2:0] M_J   = 3'd2;
    localparam logic [2:0] M_JAL = 3'd3;
    localparam logic [2:0] M_JR  = 3'd4;
    localparam logic [2:0] M_RET = 3'd5;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     ras_ptr;   // slot holding the newest entry
    logic [PW-1:0]     ras_ptr_inc;
    logic [PW:0]       ras_cnt;

    logic [ADDR_W-1:0] br_off, j_tgt, jr_tgt, pc_next;
    logic              push, pop;

    assign pc_plus4    = pc + ADDR_W'(4);
    assign br_off      = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_tgt       = {pc_plus4[ADDR_W-1:IDX_W+2], instr_idx, 2'b00};
    assign jr_tgt      = {reg_target[ADDR_W-1:2], 2'b00};
    assign ras_ptr_inc = ras_ptr + PW'(1);

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == (PW+1)'(RAS_DEPTH));
    // Popped slots are not cleared, so mask the read when the stack is empty.
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];

    // Next-PC select and stack operation decode. Reserved modes fall to SEQ.
    always_comb begin
        pc_next = pc_plus4;
        push    = 1'b0;
        pop     = 1'b0;
        case (mode)
            M_BR:  if (br_taken) pc_next = pc_plus4 + br_off;
            M_J:   pc_next = j_tgt;
            M_JAL: begin
                pc_next = j_tgt;
                push    = 1'b1;
            end
            M_JR:  pc_next = jr_tgt;
            M_RET: begin
                if (!ras_empty) begin
                    pc_next = ras_top;
                    pop     = 1'b1;
                end else begin
                    pc_next = jr_tgt;
                end
            end
            default: ;
        endcase
    end

    // PC and stack state. A stall freezes everything, including the overflow flag.
    // A push onto a full stack lands on the oldest slot, which is the one after the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_ovf <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (!stall) begin
            pc <= pc_next;
            if (push) begin
                ras_ptr              <= ras_ptr_inc;
                ras_mem[ras_ptr_inc] <= pc_plus4;
                if (ras_full) ras_ovf <= 1'b1;
                else          ras_cnt <= ras_cnt + (PW+1)'(1);
            end else if (pop) begin
                ras_ptr <= ras_ptr - PW'(1);
                ras_cnt <= ras_cnt - (PW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_jump_unit.sv
// tb_pc_jump_unit: directed vectors with hand-computed expected PCs and stack state.
module tb_pc_jump_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  mode;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_idx;
    logic [31:0] reg_target;
    logic [31:0] pc, pc_plus4, ras_top;
    logic        ras_empty, ras_full, ras_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    pc_jump_unit #(.ADDR_W(32), .IDX_W(26), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .mode(mode), .br_taken(br_taken),
        .imm16(imm16), .instr_idx(instr_idx), .reg_target(reg_target), .pc(pc),
        .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one mode for one rising edge, then settle for sampling.
    task automatic go(input logic [2:0] m);
        mode = m;
        @(posedge clk);
        #1;
        mode = 3'd0;
    endtask

    task automatic jr_to(input logic [31:0] a);
        reg_target = a;
        go(3'd4);
    endtask

    task automatic jal(input logic [25:0] idx);
        instr_idx = idx;
        go(3'd3);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; mode = 3'd0; br_taken = 1'b0;
        imm16 = '0; instr_idx = '0; reg_target = '0;
        #1;
        // 1: reset state and sequential fetch
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_ovf", ras_ovf, 0);
        chk("rst_top", ras_top, 0);
        @(negedge clk); rst_n = 1'b1;
        go(3'd0); chk("seq1", pc, 32'h4);
        go(3'd0); chk("seq2", pc, 32'h8);
        go(3'd6); chk("seq3_reserved", pc, 32'hC);

        // 2: branches
        jr_to(32'h100); chk("jr_100", pc, 32'h100);
        imm16 = 16'hFFFE; br_taken = 1'b1; go(3'd1); chk("br_back", pc, 32'hFC);
        jr_to(32'h100);
        br_taken = 1'b0; go(3'd1); chk("br_not", pc, 32'h104);
        jr_to(32'h100);
        imm16 = 16'h0003; br_taken = 1'b1; go(3'd1); chk("br_fwd", pc, 32'h110);
        br_taken = 1'b0;

        // 3: J keeps upper bits of pc+4; SEQ wraps
        jr_to(32'hF000_0000);
        jal_free: begin instr_idx = 26'h10; go(3'd2); end
        chk("j_upper", pc, 32'hF000_0040);
        jr_to(32'hFFFF_FFFF); chk("jr_mis", pc, 32'hFFFF_FFFC);
        go(3'd0); chk("seq_wrap", pc, 32'h0);

        // 4: JAL/RET pair
        jr_to(32'h200);
        jal(26'h100);
        chk("jal_pc", pc, 32'h400);
        chk("jal_top", ras_top, 32'h204);
        chk("jal_nempty", ras_empty, 0);
        go(3'd5);
        chk("ret_pc", pc, 32'h204);
        chk("ret_empty", ras_empty, 1);
        chk("ret_top0", ras_top, 0);

        // 5: overflow drops the oldest entry (0x14)
        jr_to(32'h10);
        jal(26'h100); jal(26'h200); jal(26'h300);
        chk("ovf_nfull", ras_full, 0);
        jal(26'h400);
        chk("ovf_full4", ras_full, 1);
        chk("ovf_not_yet", ras_ovf, 0);
        jal(26'h500);
        chk("ovf_pc", pc, 32'h1400);
        chk("ovf_full", ras_full, 1);
        chk("ovf_flag", ras_ovf, 1);
        chk("ovf_top", ras_top, 32'h1004);
        reg_target = 32'h1003;
        go(3'd5); chk("pop1", pc, 32'h1004);
        chk("pop1_nfull", ras_full, 0);
        go(3'd5); chk("pop2", pc, 32'hC04);
        go(3'd5); chk("pop3", pc, 32'h804);
        go(3'd5); chk("pop4", pc, 32'h404);
        chk("pop4_empty", ras_empty, 1);
        go(3'd5); chk("ret_fallback", pc, 32'h1000);
        chk("ovf_sticky", ras_ovf, 1);

        // 6: stall holds everything, async reset clears immediately
        jal(26'h80);
        chk("pre_stall_pc", pc, 32'h200);
        chk("pre_stall_top", ras_top, 32'h1004);
        stall = 1'b1;
        jal(26'h90);
        chk("stall_pc", pc, 32'h200);
        chk("stall_top", ras_top, 32'h1004);
        stall = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_empty", ras_empty, 1);
        chk("arst_top", ras_top, 0);
        chk("arst_ovf", ras_ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        go(3'd0); chk("post_rst", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
